// File: rtl/zic_irq_gateway.sv
`default_nettype none
// ============================================================================
//  Module   : zic_irq_gateway
//  Purpose  : External-interrupt gateway for the ZIC. Each line is gated by
//             its enable, captured either as a level (non-sticky) or as a
//             rising edge (sticky until acknowledged by ID), and a
//             fixed-priority selector presents the ID of the lowest-index
//             pending line to the core.
//  Config   : `define ZIC_IRQ_SYNC_EN to insert a 2-flop synchronizer on
//             every irq_in line. This raises input-to-output latency from
//             1 to 3 cycles. Without it, irq_in must already be synchronous
//             to zic_clk.
//  Ports    :
//    zic_clk                    in   block clock
//    zic_rst                    in   synchronous active-high reset
//    wdt_reset_i                in   watchdog soft reset, same effect as zic_rst
//    irq_in[NUM_IRQ]            in   external interrupt lines
//    interrupt_enable_i         in   per-line enable
//    irq_edge_mode_i            in   per-line mode, 1 = rising edge, 0 = level
//    ack_in                     in   one-cycle acknowledge strobe
//    ack_id[ID_W]               in   ID being acknowledged
//    interrupt_pending_o        out  registered pending bank
//    interrupt_pending_valid_o  out  pending bank valid (1 after reset release)
//    irq_req_o                  out  any line pending
//    irq_id_o[ID_W]             out  ID of the lowest-index pending line, else 0
//  Revision : 1.0  initial parametrised release
// ============================================================================
module zic_irq_gateway #(
  parameter int NUM_IRQ = 48,
  parameter int ID_BASE = 16,
  parameter int ID_W    = 8
) (
  input  logic               zic_clk,
  input  logic               zic_rst,
  input  logic               wdt_reset_i,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] interrupt_enable_i,
  input  logic [NUM_IRQ-1:0] irq_edge_mode_i,
  input  logic               ack_in,
  input  logic [ID_W-1:0]    ack_id,
  output logic [NUM_IRQ-1:0] interrupt_pending_o,
  output logic               interrupt_pending_valid_o,
  output logic               irq_req_o,
  output logic [ID_W-1:0]    irq_id_o
);

  // --------------------------------------------------------------------------
  // Parameter legality: every line ID must fit in ID_W bits.
  // --------------------------------------------------------------------------
  localparam longint MAX_ID  = longint'(ID_BASE) + longint'(NUM_IRQ) - 64'sd1;
  localparam longint ID_SPAN = 64'sd1 <<< ID_W;

  generate
    if (NUM_IRQ < 1 || NUM_IRQ > 64) begin : g_num_irq_err
      $error("zic_irq_gateway: NUM_IRQ must be in 1..64");
    end
    if (MAX_ID >= ID_SPAN) begin : g_id_width_err
      $error("zic_irq_gateway: ID_BASE+NUM_IRQ-1 does not fit in ID_W bits");
    end
  endgenerate

  // Both reset sources have identical effect on every flop in the block.
  logic blk_rst;
  assign blk_rst = zic_rst | wdt_reset_i;

  // --------------------------------------------------------------------------
  // Sampled input s
  // --------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] s;

`ifdef ZIC_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q;
  logic [NUM_IRQ-1:0] sync2_q;

  always_ff @(posedge zic_clk) begin
    if (blk_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = irq_in;
`endif

  // --------------------------------------------------------------------------
  // Edge history. Tracks s every cycle regardless of enable, so enabling a
  // line that is already steady high does not manufacture a rise. Cleared by
  // reset, so a line high across reset release yields exactly one rise.
  // --------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] s_prev_q;
  logic [NUM_IRQ-1:0] rise;

  always_ff @(posedge zic_clk) begin
    if (blk_rst) begin
      s_prev_q <= '0;
    end else begin
      s_prev_q <= s;
    end
  end

  assign rise = s & ~s_prev_q;

  // --------------------------------------------------------------------------
  // Per-line acknowledge decode and pending next state.
  // IDs outside the gateway's range match no line and are ignored.
  // --------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] hit;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;

  generate
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
      localparam logic [ID_W-1:0] LINE_ID = ID_W'(ID_BASE + i);

      assign hit[i] = ack_in && (ack_id == LINE_ID);

      // Edge mode: a rise in the ack cycle wins, so a new edge is never lost.
      // Level mode: pending simply follows the line, masked in the ack cycle.
      assign pending_d[i] = !interrupt_enable_i[i] ? 1'b0 :
                            irq_edge_mode_i[i]     ? (rise[i] | (pending_q[i] & ~hit[i])) :
                                                     (s[i] & ~hit[i]);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Request and fixed-priority ID, computed from the pending next state so
  // they are registered in the same cycle as the pending bank.
  // --------------------------------------------------------------------------
  logic            irq_req_d;
  logic [ID_W-1:0] irq_id_d;

  always_comb begin
    irq_req_d = |pending_d;
    irq_id_d  = '0;
    // Scan high to low so the lowest set index is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_d[i]) begin
        irq_id_d = ID_W'(ID_BASE + i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  logic            valid_q;
  logic            irq_req_q;
  logic [ID_W-1:0] irq_id_q;

  always_ff @(posedge zic_clk) begin
    if (blk_rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= 1'b1;
      irq_req_q <= irq_req_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign interrupt_pending_o       = pending_q;
  assign interrupt_pending_valid_o = valid_q;
  assign irq_req_o                 = irq_req_q;
  assign irq_id_o                  = irq_id_q;

endmodule
`default_nettype wire

// File: tb/tb_zic_irq_gateway.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zic_irq_gateway
//  Purpose  : Directed self-checking bench for zic_irq_gateway with default
//             parameters. Exercises synchronizer latency and reset abort
//             when ZIC_IRQ_SYNC_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zic_irq_gateway;

  localparam int NUM_IRQ = 48;
  localparam int ID_BASE = 16;
  localparam int ID_W    = 8;

  logic               zic_clk;
  logic               zic_rst;
  logic               wdt_reset_i;
  logic [NUM_IRQ-1:0] irq_in;
  logic [NUM_IRQ-1:0] interrupt_enable_i;
  logic [NUM_IRQ-1:0] irq_edge_mode_i;
  logic               ack_in;
  logic [ID_W-1:0]    ack_id;
  logic [NUM_IRQ-1:0] interrupt_pending_o;
  logic               interrupt_pending_valid_o;
  logic               irq_req_o;
  logic [ID_W-1:0]    irq_id_o;

  int n_checks;
  int n_fail;

  zic_irq_gateway #(
    .NUM_IRQ (NUM_IRQ),
    .ID_BASE (ID_BASE),
    .ID_W    (ID_W)
  ) u_dut (
    .zic_clk                   (zic_clk),
    .zic_rst                   (zic_rst),
    .wdt_reset_i               (wdt_reset_i),
    .irq_in                    (irq_in),
    .interrupt_enable_i        (interrupt_enable_i),
    .irq_edge_mode_i           (irq_edge_mode_i),
    .ack_in                    (ack_in),
    .ack_id                    (ack_id),
    .interrupt_pending_o       (interrupt_pending_o),
    .interrupt_pending_valid_o (interrupt_pending_valid_o),
    .irq_req_o                 (irq_req_o),
    .irq_id_o                  (irq_id_o)
  );

  initial zic_clk = 1'b0;
  always #5 zic_clk = ~zic_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one posedge and settle just after it.
  task automatic tick();
    @(posedge zic_clk);
    #1;
  endtask

  function automatic logic [NUM_IRQ-1:0] bitv(input int idx);
    logic [NUM_IRQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic ack(input int id);
    ack_in = 1'b1;
    ack_id = ID_W'(id);
  endtask

  task automatic no_ack();
    ack_in = 1'b0;
    ack_id = '0;
  endtask

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    zic_rst            = 1'b1;
    wdt_reset_i        = 1'b0;
    irq_in             = '0;
    interrupt_enable_i = '0;
    irq_edge_mode_i    = '0;
    ack_in             = 1'b0;
    ack_id             = '0;

    tick();
    tick();
    chk("rst_pending", 64'(interrupt_pending_o), 64'h0);
    chk("rst_valid",   64'(interrupt_pending_valid_o), 64'h0);
    chk("rst_req",     64'(irq_req_o), 64'h0);
    chk("rst_id",      64'(irq_id_o), 64'h0);

    zic_rst = 1'b0;
    // All lines enabled and edge mode, except line 5 which is level.
    interrupt_enable_i = '1;
    irq_edge_mode_i    = ~bitv(5);
    tick();
    chk("valid_after_release", 64'(interrupt_pending_valid_o), 64'h1);
    chk("idle_pending",        64'(interrupt_pending_o), 64'h0);

`ifndef ZIC_IRQ_SYNC_EN
    // ---- 1: edge line 3 ----
    irq_in = bitv(3);
    tick();
    chk("t1_pending", 64'(interrupt_pending_o), 64'h8);
    chk("t1_req",     64'(irq_req_o), 64'h1);
    chk("t1_id",      64'(irq_id_o), 64'd19);
    irq_in = '0;
    tick();
    chk("t1_sticky", 64'(interrupt_pending_o), 64'h8);
    ack(19);
    tick();
    no_ack();
    chk("t1_ack_pending", 64'(interrupt_pending_o), 64'h0);
    chk("t1_ack_req",     64'(irq_req_o), 64'h0);
    chk("t1_ack_id",      64'(irq_id_o), 64'h0);

    // ---- 2: level line 5 ----
    irq_in = bitv(5);
    tick();
    chk("t2_pending", 64'(interrupt_pending_o), 64'h20);
    chk("t2_id",      64'(irq_id_o), 64'd21);
    ack(21);
    tick();
    no_ack();
    chk("t2_ack_drop", 64'(interrupt_pending_o), 64'h0);
    tick();
    chk("t2_reassert", 64'(interrupt_pending_o), 64'h20);
    irq_in = '0;
    tick();
    chk("t2_line_low", 64'(interrupt_pending_o), 64'h0);

    // ---- 3: priority between lines 10 and 40 ----
    irq_in = bitv(10) | bitv(40);
    tick();
    irq_in = '0;
    chk("t3_pending", 64'(interrupt_pending_o), 64'h0000_0100_0000_0400);
    chk("t3_id_low",  64'(irq_id_o), 64'd26);
    ack(26);
    tick();
    chk("t3_id_next", 64'(irq_id_o), 64'd56);
    ack(56);
    tick();
    no_ack();
    chk("t3_req_none", 64'(irq_req_o), 64'h0);
    chk("t3_id_none",  64'(irq_id_o), 64'h0);

    // ---- 4: set wins over simultaneous ack; out-of-range ack ignored ----
    irq_in = bitv(7);
    tick();
    irq_in = '0;
    tick();
    chk("t4_pending", 64'(interrupt_pending_o), 64'h80);
    irq_in = bitv(7);
    ack(23);
    tick();
    chk("t4_set_wins", 64'(interrupt_pending_o), 64'h80);
    irq_in = '0;
    ack(200);
    tick();
    chk("t4_bad_ack_pending", 64'(interrupt_pending_o), 64'h80);
    chk("t4_bad_ack_id",      64'(irq_id_o), 64'd23);
    ack(23);
    tick();
    no_ack();
    chk("t4_cleared", 64'(interrupt_pending_o), 64'h0);

    // ---- 5: enable gating, steady-high enable, watchdog reset ----
    interrupt_enable_i = ~bitv(0);
    irq_in = bitv(0);
    tick();
    chk("t5_disabled_pulse", 64'(interrupt_pending_o), 64'h0);
    irq_in = '0;
    tick();
    irq_in = bitv(0);
    tick();
    interrupt_enable_i = '1;
    tick();
    chk("t5_enable_steady_high", 64'(interrupt_pending_o), 64'h0);
    irq_in = '0;
    tick();

    // Mode change while pending: line 9 edge-pending, switched to level
    // with the line low, drops out on the next cycle.
    irq_in = bitv(9);
    tick();
    irq_in = '0;
    chk("t5_mode_edge", 64'(interrupt_pending_o), 64'h200);
    irq_edge_mode_i = ~(bitv(5) | bitv(9));
    tick();
    chk("t5_mode_level", 64'(interrupt_pending_o), 64'h0);
    irq_edge_mode_i = ~bitv(5);

    irq_in = bitv(3) | bitv(12);
    tick();
    chk("t5_pre_wdt", 64'(interrupt_pending_o), 64'h1008);
    irq_in = bitv(12);
    wdt_reset_i = 1'b1;
    tick();
    chk("t5_wdt_pending", 64'(interrupt_pending_o), 64'h0);
    chk("t5_wdt_valid",   64'(interrupt_pending_valid_o), 64'h0);
    chk("t5_wdt_req",     64'(irq_req_o), 64'h0);
    chk("t5_wdt_id",      64'(irq_id_o), 64'h0);
    wdt_reset_i = 1'b0;
    tick();
    chk("t5_valid_back", 64'(interrupt_pending_valid_o), 64'h1);
    // Line 12 held high across reset produces one rise after release.
    chk("t5_rise_after_rst", 64'(interrupt_pending_o), 64'h1000);
    chk("t5_rise_id",        64'(irq_id_o), 64'd28);
    irq_in = '0;
    ack(28);
    tick();
    no_ack();
    chk("t5_final_clear", 64'(interrupt_pending_o), 64'h0);
`else
    // ---- 6: synchronizer latency and reset abort ----
    irq_in = bitv(3);
    tick();
    irq_in = '0;
    tick();
    chk("t6_not_yet", 64'(interrupt_pending_o), 64'h0);
    tick();
    chk("t6_pending", 64'(interrupt_pending_o), 64'h8);
    chk("t6_id",      64'(irq_id_o), 64'd19);
    ack(19);
    tick();
    no_ack();
    chk("t6_cleared", 64'(interrupt_pending_o), 64'h0);

    irq_in = bitv(4);
    tick();
    irq_in  = '0;
    zic_rst = 1'b1;
    tick();
    zic_rst = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_abort_pending", 64'(interrupt_pending_o), 64'h0);
    chk("t6_abort_req",     64'(irq_req_o), 64'h0);
    chk("t6_abort_valid",   64'(interrupt_pending_valid_o), 64'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
